// File: rtl/phase_scheduler.sv
// Five-phase instruction-cycle sequencer (fetch, decode, ALU, memory, writeback)
// with start/halt control, P4 memory-wait stall with timeout, and retired counter.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// RUN   | rotating one-hot phase P1..P5
// WAIT  | stalled in P4 for mem_ack, timeout counter running
// HALT  | stopped by HLT in P5, start resumes at P1
// ERR   | memory timeout, sticky until reset
module phase_scheduler #(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             inst_is_mem,
    input  logic             inst_wr_reg,
    input  logic             mem_ack,
    output logic [4:0]       phase,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             mem_req,
    output logic             reg_we,
    output logic             running,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [4:0] P1 = 5'b00001;
    localparam logic [4:0] P4 = 5'b01000;
    localparam logic [4:0] P5 = 5'b10000;

    state_t           state, state_n;
    logic [4:0]       phase_n;
    logic [CNT_W-1:0] retired_n;
    logic [TO_W-1:0]  to_cnt, to_cnt_n;
    logic             err_n, running_n, halted_n, pc_inc_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            phase   <= '0;
            retired <= '0;
            to_cnt  <= '0;
            err     <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b0;
            pc_inc  <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            retired <= retired_n;
            to_cnt  <= to_cnt_n;
            err     <= err_n;
            running <= running_n;
            halted  <= halted_n;
            pc_inc  <= pc_inc_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        retired_n = retired;
        to_cnt_n  = to_cnt;
        err_n     = err;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_n = S_RUN;
                    phase_n = P1;
                end
            end
            S_RUN: begin
                case (phase)
                    P4: begin
                        if (inst_is_mem && !mem_ack) begin
                            state_n  = S_WAIT;
                            to_cnt_n = TO_W'(1);
                        end else begin
                            phase_n = P5;
                        end
                    end
                    P5: begin
                        retired_n = retired + CNT_W'(1);
                        if (halt_req) begin
                            state_n = S_HALT;
                            phase_n = '0;
                        end else begin
                            phase_n = P1;
                        end
                    end
                    default: phase_n = {phase[3:0], phase[4]};
                endcase
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_n  = S_RUN;
                    phase_n  = P5;
                    to_cnt_n = '0;
                end else if (to_cnt == TO_W'(MEM_TIMEOUT)) begin
                    state_n  = S_ERR;
                    phase_n  = '0;
                    err_n    = 1'b1;
                    to_cnt_n = '0;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end
            S_ERR: begin
                phase_n = '0;
                err_n   = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                phase_n = '0;
            end
        endcase
        // Status flags are registered from the next state so they line up with phase.
        running_n = (state_n == S_RUN) || (state_n == S_WAIT);
        halted_n  = (state_n == S_HALT);
        pc_inc_n  = (state_n == S_RUN) && (phase_n == P5);
    end

    assign ir_load = phase[0];
    assign reg_we  = phase[4] & inst_wr_reg & ~err;
    assign mem_req = ((state == S_RUN) && phase[3] && inst_is_mem) || (state == S_WAIT);

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: rotation, memory stall/timeout, halt/resume,
// reset mid-wait and retired-counter wrap on a narrow-counter second instance.
module tb_phase_scheduler;

    logic        clock = 1'b0;
    logic        reset, start, halt_req, inst_is_mem, inst_wr_reg, mem_ack;
    logic [4:0]  phase, phase4;
    logic        ir_load, pc_inc, mem_req, reg_we, running, halted, err;
    logic        ir_load4, pc_inc4, mem_req4, reg_we4, running4, halted4, err4;
    logic [15:0] retired;
    logic [3:0]  retired4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    phase_scheduler #(.CNT_W(16), .TO_W(4), .MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
        .inst_is_mem(inst_is_mem), .inst_wr_reg(inst_wr_reg), .mem_ack(mem_ack),
        .phase(phase), .ir_load(ir_load), .pc_inc(pc_inc), .mem_req(mem_req),
        .reg_we(reg_we), .running(running), .halted(halted), .err(err),
        .retired(retired)
    );

    phase_scheduler #(.CNT_W(4), .TO_W(4), .MEM_TIMEOUT(15)) dut4 (
        .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
        .inst_is_mem(inst_is_mem), .inst_wr_reg(inst_wr_reg), .mem_ack(mem_ack),
        .phase(phase4), .ir_load(ir_load4), .pc_inc(pc_inc4), .mem_req(mem_req4),
        .reg_we(reg_we4), .running(running4), .halted(halted4), .err(err4),
        .retired(retired4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, mreq_cnt, we_seen;
        reset = 1'b0; start = 1'b0; halt_req = 1'b0;
        inst_is_mem = 1'b0; inst_wr_reg = 1'b0; mem_ack = 1'b0;
        do_reset();

        check("rst_phase",   32'(phase),   32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_halted",  32'(halted),  32'h0);
        check("rst_err",     32'(err),     32'h0);
        check("rst_pc_inc",  32'(pc_inc),  32'h0);

        // plain rotation, two non-memory instructions
        inst_wr_reg = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("rot_phase",   32'(phase),   32'(5'b00001 << (i % 5)));
            check("rot_pc_inc",  32'(pc_inc),  32'((i % 5) == 4));
            check("rot_reg_we",  32'(reg_we),  32'((i % 5) == 4));
            check("rot_ir_load", 32'(ir_load), 32'((i % 5) == 0));
            check("rot_running", 32'(running), 32'h1);
            tick();
        end
        check("rot_retired", 32'(retired), 32'd2);
        check("rot_phase4",  32'(phase4),  32'h01);

        // memory instruction, ack 3 cycles after P4 entry
        c0 = cyc;
        inst_is_mem = 1'b1;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            check("mw_phase",   32'(phase),   32'h08);
            check("mw_mem_req", 32'(mem_req), 32'h1);
            check("mw_running", 32'(running), 32'h1);
            mem_ack = (k == 3);
            tick();
        end
        mem_ack = 1'b0;
        check("mw_p5",      32'(phase),   32'h10);
        check("mw_pc_inc",  32'(pc_inc),  32'h1);
        check("mw_req_off", 32'(mem_req), 32'h0);
        tick();
        check("mw_latency", 32'(cyc - c0), 32'd8);
        check("mw_retired", 32'(retired),  32'd3);

        // memory instruction acked on P4 entry; ack held high throughout is ignored elsewhere
        c0 = cyc;
        mem_ack = 1'b1;
        mreq_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            mreq_cnt += 32'(mem_req);
            tick();
        end
        mem_ack = 1'b0;
        check("m0_req_cycles", 32'(mreq_cnt),  32'd1);
        check("m0_phase",      32'(phase),     32'h01);
        check("m0_latency",    32'(cyc - c0),  32'd5);
        check("m0_retired",    32'(retired),   32'd4);

        // timeout: ack never arrives
        tick(); tick(); tick();
        check("to_p4", 32'(phase), 32'h08);
        n = 0;
        we_seen = 0;
        while (phase == 5'h08 && n < 40) begin
            we_seen |= 32'(reg_we);
            n++;
            tick();
        end
        check("to_held_cycles", 32'(n),       32'd16);
        check("to_err",         32'(err),     32'h1);
        check("to_phase",       32'(phase),   32'h0);
        check("to_running",     32'(running), 32'h0);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            we_seen |= 32'(reg_we);
            tick();
        end
        start = 1'b0;
        check("to_start_ign_ph",  32'(phase), 32'h0);
        check("to_start_ign_err", 32'(err),   32'h1);
        check("to_reg_we_never",  32'(we_seen), 32'h0);
        check("to_mem_req_off",   32'(mem_req), 32'h0);
        do_reset();
        check("to_rst_err",     32'(err),     32'h0);
        check("to_rst_retired", 32'(retired), 32'h0);

        // halt_req ignored outside P5, honoured in P5
        inst_is_mem = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        check("h_p3", 32'(phase), 32'h04);
        halt_req = 1'b0;
        tick(); tick(); tick();
        check("h_noh_phase",  32'(phase),  32'h01);
        check("h_noh_halted", 32'(halted), 32'h0);
        check("h_noh_ret",    32'(retired), 32'd1);
        tick(); tick(); tick(); tick();
        check("h_p5", 32'(phase), 32'h10);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("h_halted",  32'(halted),  32'h1);
        check("h_phase",   32'(phase),   32'h0);
        check("h_running", 32'(running), 32'h0);
        check("h_retired", 32'(retired), 32'd2);
        tick();
        check("h_stay", 32'(halted), 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("h_res_phase",  32'(phase),   32'h01);
        check("h_res_halted", 32'(halted),  32'h0);
        check("h_res_ret",    32'(retired), 32'd2);

        // reset during WAIT
        inst_is_mem = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check("rw_in_wait", 32'(mem_req), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_phase",   32'(phase),   32'h0);
        check("rw_running", 32'(running), 32'h0);
        check("rw_halted",  32'(halted),  32'h0);
        check("rw_err",     32'(err),     32'h0);
        check("rw_retired", 32'(retired), 32'h0);
        check("rw_pc_inc",  32'(pc_inc),  32'h0);
        check("rw_mem_req", 32'(mem_req), 32'h0);
        check("rw_reg_we",  32'(reg_we),  32'h0);
        check("rw_ir_load", 32'(ir_load), 32'h0);

        // 17 instructions: narrow counter wraps to 1
        inst_is_mem = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 85; k++) tick();
        check("wrap_retired4", 32'(retired4), 32'd1);
        check("wrap_retired",  32'(retired),  32'd17);
        check("wrap_phase",    32'(phase),    32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Sequences the CPU's five-phase instruction cycle: P1 fetch, P2 decode/register read, P3 ALU, P4 memory, P5 writeback.
- Holds its own one-hot phase state, so the whole register-transfer datapath is clocked from one place.
- Adds start/halt control, a memory-wait stall in P4 with timeout, and a retired-instruction counter.
- Sits between the top-level CPU and the datapath enables.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- TO_W, 4, width of memory-wait timeout counter
- MEM_TIMEOUT, 15, P4 wait cycles before error (must fit TO_W, ≥1)

Ports:
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; leave IDLE/HALT and begin at P1
- halt_req  in  1  from decoder, sampled in P5 only (HLT instruction)
- inst_is_mem  in  1  current instruction uses P4 memory access, valid P2–P5
- inst_wr_reg  in  1  current instruction writes register file, valid P2–P5
- mem_ack  in  1  memory completion, sampled in P4 only
- phase  out  5  one-hot active phase, bit0=P1 … bit4=P5; 0 when not running
- ir_load  out  1  =phase[0]
- pc_inc  out  1  high on the P5 cycle that completes an instruction
- mem_req  out  1  high in P4 while inst_is_mem, until ack/timeout
- reg_we  out  1  =phase[4] & inst_wr_reg & ~err
- running  out  1  state RUN or WAIT
- halted  out  1  state HALT
- err  out  1  sticky memory timeout flag
- retired  out  CNT_W  count of completed instructions

Behaviour:
- States: IDLE, RUN, WAIT, HALT, ERR. All outputs registered except ir_load/reg_we/mem_req, which decode registered state.
- Reset (any state, mid-instruction included) → IDLE, phase=0, retired=0, err=0, halted=0, running=0, timeout counter=0.
- IDLE: start=1 → RUN, phase=00001 next cycle.
- RUN: phase rotates one position per cycle P1→P2→P3→P4→P5→P1.
- RUN, P4:
  - inst_is_mem=0 → advance to P5 next cycle.
  - inst_is_mem=1 and mem_ack=1 in the same cycle → advance to P5, zero-cycle wait.
  - inst_is_mem=1 and mem_ack=0 → WAIT, phase held at 01000, timeout counter=1.
- WAIT:
  - mem_req=1; phase held.
  - mem_ack=1 → RUN with phase P5 next cycle; counter cleared.
  - mem_ack=0 and counter==MEM_TIMEOUT → ERR, err=1, phase=0.
  - Otherwise counter+1.
- P5 completion:
  - pc_inc=1.
  - retired+1, wraps modulo 2^CNT_W, no saturation.
  - halt_req=1 → HALT, phase=0.
  - Otherwise P1.
- HALT: halted=1. start=1 → RUN at P1; retired preserved.
- ERR: phase=0, err=1. Only reset exits.
- start is ignored in RUN/WAIT/ERR.
- halt_req outside P5 is ignored.
- mem_ack outside P4/WAIT is ignored.
- Latency: non-memory instruction = 5 cycles; memory instruction = 5 + n cycles, where n is the number of cycles mem_ack is low after P4 entry.
- Exactly one phase bit is high whenever running=1; phase=0 otherwise.

Test Plan:
- Reset then start pulse, inst_is_mem=0, halt_req=0, for 10 cycles → phase 01,02,04,08,10,01,…; pc_inc on cycles 5 and 10; retired=2.
- Memory instruction, mem_ack raised 3 cycles after P4 entry → phase held 01000 for 4 cycles, mem_req high throughout, then P5; instruction takes 8 cycles.
- Memory instruction, mem_ack high on P4 entry → no WAIT, 5-cycle instruction, mem_req high exactly 1 cycle.
- mem_ack never asserted, MEM_TIMEOUT=15 → ERR after 15 WAIT cycles, err=1, phase=0, reg_we never asserted; start ignored; reset clears err.
- halt_req=1 in P3 then 0 in P5 → no halt; halt_req=1 in P5 → halted=1, phase=0, retired incremented; start resumes at P1 with retired preserved.
- Reset asserted during WAIT; separately, CNT_W=4 run of 17 instructions → IDLE with all outputs zero; retired wraps to 1.
